// File: rtl/psum_accum_pkg.sv
// Shared types and helpers for the psum accumulation engine.
// Lane limits are functions of the lane width so every instance derives its own clamps.
package psum_accum_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      OUT   = 2'd3
   } state_t;

   localparam int PSUM_BW_DEFAULT = 16;

   function automatic logic signed [31:0] psum_max(input int bw);
      return (32'sd1 <<< (bw - 1)) - 32'sd1;
   endfunction

   function automatic logic signed [31:0] psum_min(input int bw);
      return -(32'sd1 <<< (bw - 1));
   endfunction

   localparam logic signed [31:0] PSUM_MAX = psum_max(PSUM_BW_DEFAULT);
   localparam logic signed [31:0] PSUM_MIN = psum_min(PSUM_BW_DEFAULT);

   function automatic int lane_lsb(input int lane, input int bw);
      return lane * bw;
   endfunction

endpackage

// File: rtl/sat_add_lane.sv
// Combinational signed saturating adder for one psum lane.
// The sum is formed one bit wider; disagreement of the top two bits marks a clamp.
module sat_add_lane
   import psum_accum_pkg::*;
#(
   parameter int W = 16
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] sum,
   output logic         ovf
);

   localparam logic [W-1:0] MAX_V = W'(psum_max(W));
   localparam logic [W-1:0] MIN_V = W'(psum_min(W));

   logic [W:0] sum_ext;

   always_comb begin
      sum_ext = {a[W-1], a} + {b[W-1], b};
      ovf     = sum_ext[W] ^ sum_ext[W-1];
      if (!ovf)
         sum = sum_ext[W-1:0];
      else if (sum_ext[W])
         sum = MIN_V;
      else
         sum = MAX_V;
   end

endmodule

// File: rtl/psum_accum_engine.sv
// Read-modify-write accumulator between the corelet outputs and the psum SRAM.
// One vector is in flight at a time, so a read never races the previous write.
module psum_accum_engine
   import psum_accum_pkg::*;
#(
   parameter int col     = 8,
   parameter int psum_bw = 16,
   parameter int ADDR_W  = 11,
   parameter int CNT_W   = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [col*psum_bw-1:0]   in_data,
   input  logic [ADDR_W-1:0]        in_addr,
   input  logic                     in_first,
   input  logic                     in_last,
   input  logic                     relu_en,
   output logic                     mem_cen,
   output logic                     mem_wen,
   output logic [ADDR_W-1:0]        mem_a,
   output logic [col*psum_bw-1:0]   mem_d,
   input  logic [col*psum_bw-1:0]   mem_q,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [col*psum_bw-1:0]   out_data,
   output logic [ADDR_W-1:0]        out_addr,
   output logic [CNT_W-1:0]         sat_cnt,
   input  logic                     sat_clr
);

   localparam int VW    = col * psum_bw;
   localparam int INC_W = $clog2(col + 1);

   state_t              state_reg, state_next;
   logic [VW-1:0]       data_reg, out_data_reg;
   logic [ADDR_W-1:0]   addr_reg, out_addr_reg;
   logic                first_reg, last_reg, relu_reg;
   logic [CNT_W-1:0]    sat_cnt_reg;
   logic [VW-1:0]       wr_vec;
   logic [col-1:0]      ovf_vec;
   logic [INC_W-1:0]    sat_inc;
   logic [CNT_W:0]      sat_sum;
   logic                accept;

   generate
      for (genvar gi = 0; gi < col; gi++) begin : g_lane
         logic [psum_bw-1:0] lane_sum, lane_val;
         logic               lane_ovf;

         sat_add_lane #(.W(psum_bw)) u_add (
            .a   (mem_q[lane_lsb(gi, psum_bw) +: psum_bw]),
            .b   (data_reg[lane_lsb(gi, psum_bw) +: psum_bw]),
            .sum (lane_sum),
            .ovf (lane_ovf)
         );

         // ReLU is applied before the write so the SRAM keeps the rectified value.
         always_comb begin
            lane_val = first_reg ? data_reg[lane_lsb(gi, psum_bw) +: psum_bw] : lane_sum;
            if (last_reg && relu_reg && lane_val[psum_bw-1])
               lane_val = '0;
         end

         assign wr_vec[lane_lsb(gi, psum_bw) +: psum_bw] = lane_val;
         assign ovf_vec[gi] = lane_ovf & ~first_reg;
      end
   endgenerate

   always_comb begin
      sat_inc = '0;
      for (int i = 0; i < col; i++)
         sat_inc = sat_inc + INC_W'(ovf_vec[i]);
   end

   assign sat_sum = {1'b0, sat_cnt_reg} + (CNT_W + 1)'(sat_inc);
   assign accept  = in_valid && (state_reg == IDLE);

   always_comb begin
      state_next = state_reg;
      in_ready   = 1'b0;
      mem_cen    = 1'b1;
      mem_wen    = 1'b1;
      mem_d      = out_data_reg;
      out_valid  = 1'b0;
      unique case (state_reg)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid)
               state_next = in_first ? WRITE : READ;
         end
         READ: begin
            mem_cen    = 1'b0;
            state_next = WRITE;
         end
         WRITE: begin
            mem_cen    = 1'b0;
            mem_wen    = 1'b0;
            mem_d      = wr_vec;
            state_next = last_reg ? OUT : IDLE;
         end
         OUT: begin
            out_valid = 1'b1;
            if (out_ready)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg    <= IDLE;
         data_reg     <= '0;
         addr_reg     <= '0;
         first_reg    <= 1'b0;
         last_reg     <= 1'b0;
         relu_reg     <= 1'b0;
         out_data_reg <= '0;
         out_addr_reg <= '0;
         sat_cnt_reg  <= '0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            data_reg  <= in_data;
            addr_reg  <= in_addr;
            first_reg <= in_first;
            last_reg  <= in_last;
            relu_reg  <= relu_en;
         end
         // The last written vector doubles as the held mem_d value and the output.
         if (state_reg == WRITE) begin
            out_data_reg <= wr_vec;
            out_addr_reg <= addr_reg;
         end
         if (sat_clr)
            sat_cnt_reg <= '0;
         else if (state_reg == WRITE)
            sat_cnt_reg <= sat_sum[CNT_W] ? '1 : sat_sum[CNT_W-1:0];
      end
   end

   assign mem_a    = addr_reg;
   assign out_data = out_data_reg;
   assign out_addr = out_addr_reg;
   assign sat_cnt  = sat_cnt_reg;

endmodule

// File: tb/tb_psum_accum_engine.sv
// Self-checking bench: directed scenarios plus random traffic against a lane-level
// model of the psum memory contents, with an SRAM model attached to the memory port.
module tb_psum_accum_engine;

   localparam int COL  = 8;
   localparam int BW   = 16;
   localparam int AW   = 11;
   localparam int CW   = 4;
   localparam int VW   = COL * BW;
   localparam int SMAX = 32767;
   localparam int SMIN = -32768;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk;
   logic          reset;
   logic          in_valid, in_ready, in_first, in_last, relu_en;
   logic [VW-1:0] in_data;
   logic [AW-1:0] in_addr;
   logic          mem_cen, mem_wen;
   logic [AW-1:0] mem_a;
   logic [VW-1:0] mem_d, mem_q;
   logic          out_valid, out_ready;
   logic [VW-1:0] out_data;
   logic [AW-1:0] out_addr;
   logic [CW-1:0] sat_cnt;
   logic          sat_clr;

   psum_accum_engine #(.col(COL), .psum_bw(BW), .ADDR_W(AW), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_addr(in_addr),
      .in_first(in_first), .in_last(in_last), .relu_en(relu_en),
      .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_a(mem_a), .mem_d(mem_d), .mem_q(mem_q),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
      .sat_cnt(sat_cnt), .sat_clr(sat_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // single-port SRAM with one cycle read latency
   logic [VW-1:0] sram [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (!mem_cen) begin
         if (!mem_wen) sram[mem_a] <= mem_d;
         else          mem_q <= sram[mem_a];
      end
   end

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: bound expired", name);
   endtask

   function automatic logic [VW-1:0] rep(input int v);
      logic [VW-1:0] r;
      for (int i = 0; i < COL; i++) r[i*BW +: BW] = v[BW-1:0];
      return r;
   endfunction

   function automatic logic [VW-1:0] mk2(input int v0, input int v1);
      logic [VW-1:0] r;
      r = '0;
      r[0 +: BW]  = v0[BW-1:0];
      r[BW +: BW] = v1[BW-1:0];
      return r;
   endfunction

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic [AW-1:0] addr;
      logic [VW-1:0] data;
      logic [7:0]    nsat;
      logic          first;
   } wr_t;

   wr_t           wq[$];
   wr_t           oq[$];
   int            gold [0:(1<<AW)-1][COL];
   int            exp_sat = 0;
   int            cyc = 0;
   int            acc_cyc, gap_exp, stalls;
   bit            gap_wait = 0, gap_last;
   logic [VW-1:0] last_out;
   logic [AW-1:0] last_out_addr;
   wr_t           m_e;
   int            m_v, m_d, m_n;
   bit            m_wr;

   always @(negedge clk) begin
      cyc++;
      if (!reset) begin
         wq.delete();
         oq.delete();
         exp_sat  = 0;
         gap_wait = 0;
      end else begin
         check("sat_cnt", VW'(sat_cnt), VW'(exp_sat));
         m_wr = 0;
         m_n  = 0;
         if (!mem_cen && !mem_wen) begin
            if (wq.size() == 0) fail("unexpected_write");
            else begin
               m_e = wq.pop_front();
               check("wr_addr", VW'(mem_a), VW'(m_e.addr));
               check("wr_data", mem_d, m_e.data);
               m_wr = 1;
               m_n  = int'(m_e.nsat);
            end
         end else if (!mem_cen && mem_wen) begin
            if (wq.size() == 0) fail("unexpected_read");
            else begin
               check("rd_addr", VW'(mem_a), VW'(wq[0].addr));
               check("rd_on_first", VW'(wq[0].first), '0);
            end
         end
         if (out_valid) begin
            if (oq.size() == 0) fail("unexpected_out");
            else begin
               check("out_data", out_data, oq[0].data);
               check("out_addr", VW'(out_addr), VW'(oq[0].addr));
               check("in_ready_during_out", VW'(in_ready), '0);
               if (out_ready) begin
                  last_out      = oq[0].data;
                  last_out_addr = oq[0].addr;
                  void'(oq.pop_front());
               end else begin
                  stalls++;
               end
            end
         end
         if (gap_wait && in_ready) begin
            check("ready_gap", VW'(cyc - acc_cyc), VW'(gap_exp + (gap_last ? 1 + stalls : 0)));
            gap_wait = 0;
         end
         if (in_valid && in_ready) begin
            m_e       = '0;
            m_e.addr  = in_addr;
            m_e.first = in_first;
            for (int i = 0; i < COL; i++) begin
               m_d = int'($signed(in_data[i*BW +: BW]));
               if (in_first) m_v = m_d;
               else begin
                  m_v = gold[in_addr][i] + m_d;
                  if (m_v > SMAX) begin m_v = SMAX; m_e.nsat++; end
                  else if (m_v < SMIN) begin m_v = SMIN; m_e.nsat++; end
               end
               if (in_last && relu_en && m_v < 0) m_v = 0;
               gold[in_addr][i] = m_v;
               m_e.data[i*BW +: BW] = m_v[BW-1:0];
            end
            wq.push_back(m_e);
            if (in_last) oq.push_back(m_e);
            acc_cyc  = cyc;
            gap_wait = 1;
            gap_exp  = in_first ? 2 : 3;
            gap_last = in_last;
            stalls   = 0;
         end
         if (sat_clr) exp_sat = 0;
         else if (m_wr) exp_sat = (exp_sat + m_n > CMAX) ? CMAX : exp_sat + m_n;
      end
   end

   // ---------------- drivers ----------------
   int rdy_mode  = 1;
   bit clr_rand  = 0;
   bit clr_force = 0;

   always @(posedge clk) begin
      #1;
      out_ready = (rdy_mode == 0) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
      sat_clr   = clr_force | (clr_rand && $urandom_range(0, 15) == 0);
   end

   task automatic drive(input int addr, input logic [VW-1:0] d, input bit f, input bit l, input bit r);
      in_valid = 1'b1;
      in_addr  = addr[AW-1:0];
      in_data  = d;
      in_first = f;
      in_last  = l;
      relu_en  = r;
   endtask

   task automatic wait_accept();
      for (int t = 0; t < 100; t++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_data  = {4{$urandom}};
            return;
         end
      end
      fail("accept_timeout");
      in_valid = 1'b0;
   endtask

   task automatic send(input int addr, input logic [VW-1:0] d, input bit f, input bit l, input bit r);
      drive(addr, d, f, l, r);
      wait_accept();
   endtask

   task automatic wait_idle();
      for (int t = 0; t < 200; t++) begin
         @(posedge clk);
         #2;
         if (in_ready && wq.size() == 0 && oq.size() == 0) return;
      end
      fail("idle_timeout");
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_in_ready"},  VW'(in_ready),  VW'(1));
      check({tag, "_mem_cen"},   VW'(mem_cen),   VW'(1));
      check({tag, "_mem_wen"},   VW'(mem_wen),   VW'(1));
      check({tag, "_mem_a"},     VW'(mem_a),     '0);
      check({tag, "_mem_d"},     mem_d,          '0);
      check({tag, "_out_valid"}, VW'(out_valid), '0);
      check({tag, "_out_data"},  out_data,       '0);
      check({tag, "_out_addr"},  VW'(out_addr),  '0);
      check({tag, "_sat_cnt"},   VW'(sat_cnt),   '0);
   endtask

   task automatic wait_cond_read();
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         if (!mem_cen && mem_wen) return;
      end
      fail("read_timeout");
   endtask

   task automatic wait_out_valid();
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         if (out_valid) return;
      end
      fail("out_valid_timeout");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1);
   end

   initial begin
      for (int a = 0; a < (1 << AW); a++) begin
         sram[a] = '0;
         for (int i = 0; i < COL; i++) gold[a][i] = 0;
      end
      in_valid = 0; in_data = '0; in_addr = '0; in_first = 0; in_last = 0; relu_en = 0;
      out_ready = 1; sat_clr = 0;
      reset = 1'b1;
      #1 reset = 1'b0;
      #2 check_reset_vals("reset");
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;

      // 1: single-shot first+last
      send(5, rep(3), 1, 1, 0);
      wait_idle();
      check("t1_sram", sram[5], rep(3));
      check("t1_out", last_out, rep(3));
      check("t1_addr", VW'(last_out_addr), VW'(5));

      // 2: three-step accumulation
      send(7, rep(10), 1, 0, 0);
      send(7, rep(20), 0, 0, 0);
      send(7, rep(-5), 0, 1, 0);
      wait_idle();
      check("t2_sram", sram[7], rep(25));
      check("t2_out", last_out, rep(25));

      // 3: overflow and underflow clamps
      send(1, rep(32760), 1, 0, 0);
      send(1, rep(100), 0, 0, 0);
      wait_idle();
      check("t3_sram_max", sram[1], rep(SMAX));
      check("t3_sat8", VW'(sat_cnt), VW'(8));
      send(2, rep(-32700), 1, 0, 0);
      send(2, rep(-100), 0, 1, 0);
      wait_idle();
      check("t3_out_min", last_out, rep(SMIN));
      check("t3_sat_clamp", VW'(sat_cnt), VW'(CMAX));

      // 4: ReLU on the last pass
      send(9, mk2(-4, 1), 1, 0, 0);
      send(9, mk2(-5, 3), 0, 1, 1);
      wait_idle();
      check("t4_relu_out", last_out, mk2(0, 4));
      check("t4_relu_sram", sram[9], mk2(0, 4));
      send(10, mk2(-4, 1), 1, 0, 0);
      send(10, mk2(-5, 3), 0, 1, 0);
      wait_idle();
      check("t4_norelu_out", last_out, mk2(-9, 4));

      // 5: output backpressure holds the engine
      rdy_mode = 2;
      send(11, rep(1), 1, 1, 0);
      wait_out_valid();
      drive(12, rep(2), 1, 1, 0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("t5_out_valid_held", VW'(out_valid), VW'(1));
         check("t5_in_ready_low", VW'(in_ready), '0);
      end
      rdy_mode = 1;
      wait_accept();
      wait_idle();
      check("t5_out", last_out, rep(2));

      // 6a: clear wins over a saturating write
      clr_force = 1;
      send(1, rep(100), 0, 0, 0);
      wait_idle();
      clr_force = 0;
      @(negedge clk);
      check("t6_clr_priority", VW'(sat_cnt), '0);

      // random traffic
      rdy_mode = 0;
      clr_rand = 1;
      for (int n = 0; n < 150; n++) begin
         logic [VW-1:0] d;
         for (int i = 0; i < COL; i++) begin
            int v;
            if ($urandom_range(0, 2) == 0) v = int'($urandom_range(0, 65535)) - 32768;
            else v = int'($urandom_range(0, 600)) - 300;
            d[i*BW +: BW] = v[BW-1:0];
         end
         send(16 + int'($urandom_range(0, 7)), d, $urandom_range(0, 4) == 0,
              $urandom_range(0, 9) < 3, 1'($urandom_range(0, 1)));
      end
      wait_idle();
      rdy_mode = 1;
      clr_rand = 0;
      @(negedge clk);

      // 6b: reset during READ aborts asynchronously
      drive(100, rep(1), 0, 0, 0);
      wait_cond_read();
      #1 reset = 1'b0;
      in_valid = 1'b0;
      #1 check_reset_vals("rst_read");
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;

      // reset while a result is waiting in OUT
      rdy_mode = 2;
      send(101, rep(6), 1, 1, 0);
      wait_out_valid();
      #1 reset = 1'b0;
      #1 check_reset_vals("rst_out");
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      rdy_mode = 1;

      send(5, rep(-7), 1, 1, 0);
      wait_idle();
      check("post_reset_out", last_out, rep(-7));
      check("final_wq_empty", VW'(wq.size()), '0);
      check("final_oq_empty", VW'(oq.size()), '0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/psum_accum_engine.md
Name: psum_accum_engine

Overview:
- Parametrised successor to the core's psum datapath: accepts column-wide partial-sum vectors (from OFIFO or SFP), read-modify-writes them into a single-port psum SRAM, and emits the final vector of each accumulation group.
- Adds what the core lacks: in-memory accumulation, per-lane signed saturation, optional ReLU on the final pass, a valid/ready handshake and a saturation-event counter.
- Sits between the corelet output and the psum SRAM instance, replacing the direct ofifo_out/sfp_out to D wiring.

Parameters:
- col, 8, number of psum lanes.
- psum_bw, 16, signed lane width.
- ADDR_W, 11, psum SRAM address width.
- CNT_W, 16, saturation counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  input vector valid.
- in_ready  out  1  engine can accept.
- in_data  in  col*psum_bw  lane i is bits [i*psum_bw +: psum_bw], signed.
- in_addr  in  ADDR_W  target psum address.
- in_first  in  1  overwrite (no read) instead of accumulate.
- in_last  in  1  final contribution; apply ReLU if enabled, then emit.
- relu_en  in  1  sampled with each accepted vector.
- mem_cen  out  1  SRAM chip enable, active-low.
- mem_wen  out  1  SRAM write enable, active-low.
- mem_a  out  ADDR_W  SRAM address.
- mem_d  out  col*psum_bw  SRAM write data.
- mem_q  in  col*psum_bw  SRAM read data, valid 1 cycle after read issue.
- out_valid  out  1  final vector valid.
- out_ready  in  1  downstream accepts.
- out_data  out  col*psum_bw  final vector.
- out_addr  out  ADDR_W  address of final vector.
- sat_cnt  out  CNT_W  count of saturating lane-adds; saturates at all-ones.
- sat_clr  in  1  synchronous clear of sat_cnt.

Behaviour:
- FSM states: IDLE, READ, WRITE, OUT.
- Reset (reset=0, asynchronous): state=IDLE. in_ready=1; mem_cen=1; mem_wen=1; mem_a=0; mem_d=0; out_valid=0; out_data=0; out_addr=0; sat_cnt=0. All holding registers cleared.
- IDLE: in_ready=1. On in_valid&in_ready, capture data, addr, first, last and relu_en. Go to WRITE if in_first, else READ. in_ready=0 in every other state.
- READ: mem_cen=0, mem_wen=1, mem_a=held addr. Next state is WRITE.
- WRITE: mem_cen=0, mem_wen=0, mem_a=held addr.
  - mem_d = held data if first, else per-lane sat(mem_q + held data).
  - If last and relu_en, negative lanes become 0 before the write, so the SRAM holds the post-ReLU value.
  - Register the result into out_data/out_addr. Next state is OUT if last, else IDLE.
- OUT: out_valid=1 until the cycle with out_ready=1, then IDLE. out_data and out_addr are stable while out_valid=1.
- In all other cycles mem_cen=1 and mem_wen=1. mem_a and mem_d hold their last values.
- Throughput (cycles from accept to the next in_ready=1):
  - first, not last: 2.
  - accumulate, not last: 3.
  - with last: add at least 1 cycle in OUT.
- Saturation: per lane, signed add is computed at psum_bw+1 bits. Overflow clamps to 2^(psum_bw-1)-1; underflow clamps to -2^(psum_bw-1).
- sat_cnt: increments by the number of clamped lanes in a WRITE cycle (0..col) and stops at 2^CNT_W-1. sat_clr has priority over an increment in the same cycle.
- in_first=1 with in_last=1: single-shot write and emit, with no read.
- Back-to-back vectors to the same address have no hazard, because each write completes before the next accept.
- Input signals are ignored while in_ready=0. A source must hold in_valid and its data until accepted.
- Reset mid-operation: abort immediately. A pending write is lost and SRAM contents are undefined for that address. out_valid drops asynchronously.

Decomposition:
- Package psum_accum_pkg holds:
  - state enum (IDLE, READ, WRITE, OUT);
  - constants PSUM_MAX and PSUM_MIN as functions of psum_bw;
  - lane-slice helper.
- One sub-module, sat_add_lane: a combinational signed saturating adder with an overflow flag. It is instantiated col times via generate.

Test Plan:
1. Reset release, then a single vector with first=1, last=1, addr=5, all lanes 3 -> one write to address 5 with lanes 3. out_valid 2 cycles after accept, out_data lanes 3, out_addr=5.
2. Three vectors to addr 7, lanes 10, 20, -5, flagged first / mid / last+last -> reads at addr 7 on the 2nd and 3rd vectors. Final SRAM and out_data lanes 25; in_ready gaps of 2 and 3 cycles.
3. psum_bw=16: addr 1 pre-written 32760, accumulate +100 on all 8 lanes -> lanes 32767, sat_cnt=8. Then -40000-style underflow (stored -32700 plus -100) clamps to -32768.
4. relu_en=1 on the last vector, lane0 ending at -9 and lane1 at +4 -> SRAM and out lane0=0, lane1=4. With relu_en=0, lane0 stays -9.
5. out_ready held 0 for 5 cycles in OUT -> out_valid stays 1 with stable data, in_ready stays 0, and a new in_valid is not accepted until after the handshake.
6. reset asserted during READ -> all outputs return to reset values asynchronously. sat_clr together with a saturating WRITE -> sat_cnt=0.
